uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. It serialises a DATA_BITS-wide word, LSB first, with one start bit, optional odd or even parity, and one or two stop bits. A ready/valid handshake lets the upstream stage see when the transmitter can accept a word. It sits between the command/data path and the physical TX pin, next to the existing UART receiver.

Parameters:
CLKS_PER_BIT, 87, clocks per bit (i_Clock freq / baud); legal range 2..65535
DATA_BITS, 8, payload width; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; 3 is illegal and is flagged by an elaboration check
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Rst_n  in  1  reset, synchronous, active-low
i_Tx_DV  in  1  data valid; word accepted on a cycle where i_Tx_DV=1 and o_Tx_Ready=1
i_Tx_Data  in  DATA_BITS  word to transmit; sampled only on the accept cycle
o_Tx_Ready  out  1  high only in IDLE
o_Tx_Active  out  1  high from the cycle after accept through the last stop-bit clock
o_Tx_Serial  out  1  serial line, registered; idle level 1
o_Tx_Done  out  1  one-cycle pulse after the last stop-bit clock

Behaviour:
- Reset (i_Rst_n=0 at a clock edge): state=IDLE, counters=0, data register=0.
- Reset outputs: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0; o_Tx_Ready=1 from the first cycle after reset is released.
- Reset mid-frame aborts the frame immediately; the line is high on the next edge and no Done pulse is generated.
- States: IDLE -> START -> DATA -> [PARITY, only if PARITY_MODE != 0] -> STOP -> CLEANUP -> IDLE.
- IDLE: serial=1. On accept, latch i_Tx_Data, compute parity from the latched value, set Active=1, go to START.
  - i_Tx_DV while not ready is ignored; it is neither queued nor does it corrupt the frame in progress.
- START: serial=0 for CLKS_PER_BIT clocks. The first low cycle is the cycle immediately after the accept edge.
- DATA: serial=data[bit_idx], starting at bit_idx=0; each bit is held CLKS_PER_BIT clocks.
  - bit_idx increments until DATA_BITS-1, then clears.
- PARITY: bit held CLKS_PER_BIT clocks.
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- STOP: serial=1 for STOP_BITS*CLKS_PER_BIT clocks, using a stop counter of 1 bit.
  - On the final stop clock: Active goes to 0 and Done goes to 1 on the same edge.
- CLEANUP: one cycle, Done=1, serial=1. Then IDLE with Done=0.
- Frame length, start-low to stop-end: CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) clocks, where P=1 if PARITY_MODE != 0.
- Back-to-back: with i_Tx_DV held high, the next start bit begins exactly 2 clocks after the stop bits end (1 CLEANUP cycle + 1 IDLE accept cycle).
- Widths:
  - Clock counter is $clog2(CLKS_PER_BIT) bits; it compares against CLKS_PER_BIT-1, then wraps to 0.
  - bit_idx is $clog2(DATA_BITS) bits.
- Illegal state encodings recover to IDLE with serial=1.

Decomposition:
- Shared package uart_pkg:
  - State enum t_tx_state (IDLE, START, DATA, PARITY, STOP, CLEANUP).
  - PARITY_NONE/ODD/EVEN constants.
  - Function parity_bit(data, mode).
- One natural sub-module, uart_baud_tick: the CLKS_PER_BIT counter with clear input and a last-clock tick output.
  - It is reused by the receiver successor.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, send 0xA5 -> serial 0, 1,0,1,0,0,1,0,1, 1, each held 4 clocks; Done high exactly at clock 41 after accept; Active high for 40 clocks.
2. DATA_BITS=7, even parity, 2 stop bits, send 0x53 (four ones) -> parity bit 0, stop high 8 clocks, frame 44 clocks.
   - Repeat with odd parity -> parity bit 1.
3. i_Tx_DV held high with two words queued upstream (0x00 then 0xFF) -> second start bit begins 2 clocks after the first frame's stop end.
   - DV pulses during the first frame are ignored.
4. Assert i_Rst_n=0 during data bit 3 -> next edge: serial=1, Active=0, Done never pulses, Ready=1 after release.
   - A following send of 0x3C transmits cleanly.
5. DATA_BITS=9, CLKS_PER_BIT=2, send 0x1FF with odd parity -> nine 1s, parity 0, total frame 24 clocks.
6. Scoreboard: 200 random words across all parameter sets, decoded by a bench UART model -> zero mismatches, Done count equals accept count.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } t_tx_state;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;
    localparam int MAX_DATA_BITS = 9;

    // Unused upper bits of data must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - transmitter handshake and line interface
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Data;
    logic                 o_Tx_Ready;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Data,
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Data,
        output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear and last-clock tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    output logic o_Tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_Tick = (cnt_q == LAST);
        cnt_d  = (i_Clear || o_Tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (data width, parity, stop bits)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_Clock,
    input  logic          i_Rst_n,
    uart_tx_cfg_if.slave  tx
);
    localparam int IDXW = $clog2(DATA_BITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
            DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_param
            $error("uart_tx_cfg: illegal parameter combination");
        end
    endgenerate

    t_tx_state                state_q, state_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic [IDXW-1:0]          bit_idx_q, bit_idx_d;
    logic                     stop_q, stop_d;
    logic                     par_q, par_d;
    logic                     serial_q, serial_d;
    logic                     active_q, active_d;
    logic                     done_q, done_d;
    logic                     baud_clear, baud_tick;
    logic [MAX_DATA_BITS-1:0] data_ext;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Clear (baud_clear),
        .o_Tick  (baud_tick)
    );

    always_comb begin
        data_ext                  = '0;
        data_ext[DATA_BITS-1:0]   = tx.i_Tx_Data;
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_d     = stop_q;
        par_d      = par_q;
        serial_d   = serial_q;
        active_d   = active_q;
        done_d     = 1'b0;
        baud_clear = 1'b0;
        case (state_q)
            IDLE: begin
                baud_clear = 1'b1;
                serial_d   = 1'b1;
                active_d   = 1'b0;
                bit_idx_d  = '0;
                stop_d     = 1'b0;
                if (tx.i_Tx_DV) begin
                    data_d   = tx.i_Tx_Data;
                    par_d    = parity_bit(data_ext, PARITY_MODE);
                    active_d = 1'b1;
                    serial_d = 1'b0;
                    state_d  = START;
                end
            end
            START: if (baud_tick) begin
                serial_d = data_q[0];
                state_d  = DATA;
            end
            DATA: if (baud_tick) begin
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    if (PARITY_MODE != PARITY_NONE) begin
                        serial_d = par_q;
                        state_d  = PARITY;
                    end else begin
                        serial_d = 1'b1;
                        state_d  = STOP;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + IDXW'(1);
                    serial_d  = data_q[bit_idx_d];
                end
            end
            PARITY: if (baud_tick) begin
                serial_d = 1'b1;
                state_d  = STOP;
            end
            STOP: begin
                serial_d = 1'b1;
                // Done rises on the same edge Active falls, so CLEANUP carries the pulse.
                if (baud_tick) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d   = 1'b0;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = CLEANUP;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            CLEANUP: begin
                baud_clear = 1'b1;
                serial_d   = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                baud_clear = 1'b1;
                serial_d   = 1'b1;
                active_d   = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_idx_q <= '0;
            stop_q    <= 1'b0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
            stop_q    <= stop_d;
            par_q     <= par_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign tx.o_Tx_Ready  = (state_q == IDLE);
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Done   = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed and random frame checks over four parameter sets
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dv = 4'b0;
    logic [8:0] din = 9'h0;
    logic [3:0] ser, act, done, rdy;

    int n_cmp = 0;
    int n_err = 0;
    int acc [4] = '{0, 0, 0, 0};
    int dcnt[4] = '{0, 0, 0, 0};

    int cpb_t[4] = '{4, 4, 4, 2};
    int db_t [4] = '{8, 7, 7, 9};
    int pm_t [4] = '{0, 2, 1, 1};
    int sb_t [4] = '{1, 2, 2, 1};

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_b ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_c ();
    uart_tx_cfg_if #(.DATA_BITS(9)) if_d ();

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
        u_a (.i_Clock(clk), .i_Rst_n(rst_n), .tx(if_a.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2))
        u_b (.i_Clock(clk), .i_Rst_n(rst_n), .tx(if_b.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2))
        u_c (.i_Clock(clk), .i_Rst_n(rst_n), .tx(if_c.slave));
    uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1))
        u_d (.i_Clock(clk), .i_Rst_n(rst_n), .tx(if_d.slave));

    assign if_a.i_Tx_DV = dv[0];  assign if_a.i_Tx_Data = din[7:0];
    assign if_b.i_Tx_DV = dv[1];  assign if_b.i_Tx_Data = din[6:0];
    assign if_c.i_Tx_DV = dv[2];  assign if_c.i_Tx_Data = din[6:0];
    assign if_d.i_Tx_DV = dv[3];  assign if_d.i_Tx_Data = din;

    assign ser  = {if_d.o_Tx_Serial, if_c.o_Tx_Serial, if_b.o_Tx_Serial, if_a.o_Tx_Serial};
    assign act  = {if_d.o_Tx_Active, if_c.o_Tx_Active, if_b.o_Tx_Active, if_a.o_Tx_Active};
    assign done = {if_d.o_Tx_Done,   if_c.o_Tx_Done,   if_b.o_Tx_Done,   if_a.o_Tx_Done};
    assign rdy  = {if_d.o_Tx_Ready,  if_c.o_Tx_Ready,  if_b.o_Tx_Ready,  if_a.o_Tx_Ready};

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (done[i]) dcnt[i]++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame bit j (j=0 is the start bit) as seen on the line, LSB first.
    function automatic logic [15:0] model_frame(input logic [8:0] d, input int db, input int pm, input int sb);
        logic [15:0] f;
        logic        x;
        int          p;
        f = '0;
        x = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[i+1] = d[i];
            x      = x ^ d[i];
        end
        p = 1 + db;
        if (pm != 0) begin
            f[p] = (pm == 1) ? ~x : x;
            p++;
        end
        for (int s = 0; s < sb; s++) f[p+s] = 1'b1;
        return f;
    endfunction

    // Called just after a falling edge; returns on a falling edge.
    task automatic send_frame(input int idx, input logic [8:0] data, input int cpb, input int nb,
                              input logic [15:0] exp_bits, input bit hold, output int waited);
        int len;
        len    = cpb * nb;
        waited = 0;
        while (!rdy[idx] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("ready_before_send%0d", idx), {31'd0, rdy[idx]}, 32'd1);
        din     = data;
        dv[idx] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) dv[idx] = 1'b0;
        din = 9'h0AA;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (k <= len)
                chk($sformatf("frame%0d_k%0d", idx, k), {28'd0, ser[idx], act[idx], done[idx], rdy[idx]},
                    {28'd0, exp_bits[(k-1)/cpb], 3'b100});
            else
                chk($sformatf("done%0d_k%0d", idx, k), {28'd0, ser[idx], act[idx], done[idx], rdy[idx]},
                    {28'd0, 4'b1010});
            if (!hold && k == cpb + 1) dv[idx] = 1'b1;
            if (!hold && k == cpb + 2) dv[idx] = 1'b0;
        end
        acc[idx]++;
        if (!hold) begin
            @(negedge clk);
            chk($sformatf("idle_after%0d", idx), {28'd0, ser[idx], act[idx], done[idx], rdy[idx]}, {28'd0, 4'b1001});
        end
    endtask

    initial begin
        int         w;
        int         idx;
        logic [8:0] d;
        logic [8:0] mask;
        int         nb;

        repeat (3) @(negedge clk);
        chk("reset_serial", {28'd0, ser},  32'hF);
        chk("reset_active", {28'd0, act},  32'h0);
        chk("reset_done",   {28'd0, done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {28'd0, rdy}, 32'hF);

        send_frame(0, 9'h0A5, 4, 10, {6'd0, 1'b1, 8'hA5, 1'b0}, 1'b0, w);
        send_frame(1, 9'h053, 4, 11, {5'd0, 2'b11, 1'b0, 7'h53, 1'b0}, 1'b0, w);
        send_frame(2, 9'h053, 4, 11, {5'd0, 2'b11, 1'b1, 7'h53, 1'b0}, 1'b0, w);
        send_frame(3, 9'h1FF, 2, 12, {4'd0, 1'b1, 1'b0, 9'h1FF, 1'b0}, 1'b0, w);

        send_frame(0, 9'h000, 4, 10, {6'd0, 1'b1, 8'h00, 1'b0}, 1'b1, w);
        send_frame(0, 9'h0FF, 4, 10, {6'd0, 1'b1, 8'hFF, 1'b0}, 1'b0, w);
        chk("back_to_back_gap", w, 32'd1);

        din   = 9'h0A5;
        dv[0] = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("mid_frame_bit3", {30'd0, ser[0], act[0]}, 32'b01);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_line", {29'd0, ser[0], act[0], done[0]}, 32'b100);
        @(negedge clk);
        chk("abort_hold", {29'd0, ser[0], act[0], done[0]}, 32'b100);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release", {30'd0, rdy[0], done[0]}, 32'b10);
        send_frame(0, 9'h03C, 4, 10, {6'd0, 1'b1, 8'h3C, 1'b0}, 1'b0, w);

        for (int r = 0; r < 200; r++) begin
            idx  = r % 4;
            mask = 9'((1 << db_t[idx]) - 1);
            d    = 9'($urandom) & mask;
            nb   = 1 + db_t[idx] + ((pm_t[idx] != 0) ? 1 : 0) + sb_t[idx];
            send_frame(idx, d, cpb_t[idx], nb, model_frame(d, db_t[idx], pm_t[idx], sb_t[idx]), 1'b0, w);
        end

        for (int i = 0; i < 4; i++) chk($sformatf("done_count%0d", i), dcnt[i], acc[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
